// File: rtl/prog_loader.sv
// Byte-stream program loader: parses {A5, N, N x {HI,LO}, XOR} frames, writes 13-bit
// instructions to instruction memory and holds the core in reset until a frame verifies.
module prog_loader #(
  parameter int ADDR_W      = 8,
  parameter int INST_W      = 13,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [INST_W-1:0] mem_wdata,
  output logic              core_rst,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   inst_count
);

  localparam int         CW     = ADDR_W + 1;
  localparam logic [7:0] HEADER = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_HI, S_LO, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t              r_state, w_state_next;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [INST_W-1:0]   r_mem_wdata;
  logic [CW-1:0]       r_count;
  logic [CW-1:0]       r_index;
  logic [CW-1:0]       r_inst_count;
  logic [4:0]          r_hi;
  logic [7:0]          r_xor;
  logic [31:0]         r_timer;

  logic                w_active;
  logic                w_expired;
  logic                w_write;
  logic [CW-1:0]       w_idx_next;

  assign w_active   = (r_state == S_COUNT) || (r_state == S_HI) ||
                      (r_state == S_LO)    || (r_state == S_CHK);
  assign w_expired  = w_active && (r_timer >= 32'(TIMEOUT_CYC));
  assign w_idx_next = r_index + CW'(1);

  // NOTE: synchronous reset lives inside the clocked block; sequential state uses <= only
  // so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_write      = 1'b0;
    if (rx_valid) begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR:
          if (rx_data == HEADER) w_state_next = S_COUNT;
        S_COUNT: w_state_next = (rx_data == 8'h00) ? S_ERR : S_HI;
        S_HI:    w_state_next = (rx_data[7:5] != 3'b000) ? S_ERR : S_LO;
        S_LO: begin
          w_write      = 1'b1;
          w_state_next = (w_idx_next == r_count) ? S_CHK : S_HI;
        end
        S_CHK:   w_state_next = (rx_data == r_xor) ? S_DONE : S_ERR;
        default: w_state_next = S_IDLE;
      endcase
    end else if (w_expired) begin
      // an accepted byte on the expiry cycle takes priority over the timeout
      w_state_next = S_ERR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_count      <= '0;
      r_index      <= '0;
      r_inst_count <= '0;
      r_hi         <= '0;
      r_xor        <= '0;
      r_timer      <= '0;
    end else begin
      r_mem_we <= w_write;
      r_timer  <= (rx_valid || !w_active) ? 32'd0 : r_timer + 32'd1;
      if (rx_valid) begin
        case (r_state)
          S_IDLE, S_DONE, S_ERR:
            if (rx_data == HEADER) r_inst_count <= '0;
          S_COUNT: begin
            r_count <= CW'(rx_data);
            r_index <= '0;
            r_xor   <= rx_data;
          end
          S_HI: begin
            r_hi  <= rx_data[4:0];
            r_xor <= r_xor ^ rx_data;
          end
          S_LO: begin
            r_xor       <= r_xor ^ rx_data;
            r_mem_addr  <= r_index[ADDR_W-1:0];
            r_mem_wdata <= INST_W'({r_hi, rx_data});
            r_index     <= w_idx_next;
            if (r_inst_count < r_count) r_inst_count <= r_inst_count + CW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign rx_ready   = 1'b1;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign core_rst   = (r_state != S_DONE);
  assign load_done  = (r_state == S_DONE);
  assign load_err   = (r_state == S_ERR);
  assign inst_count = r_inst_count;

endmodule
